// File: rtl/ram_bist_seq.sv
// March-style BIST sequencer for a dual-port RAM: write pattern, read/check,
// write inverse with ports swapped, read/check; reports first failure and error count.
module ram_bist_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [31:0] PATTERN = 32'hA5A5A5A5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [AW-1:0]    ram_addr0,
  output logic [AW-1:0]    ram_addr1,
  output logic             ram_wr,
  output logic [WIDTH-1:0] ram_wdata0,
  output logic [WIDTH-1:0] ram_wdata1,
  input  logic [WIDTH-1:0] ram_rdata0,
  input  logic [WIDTH-1:0] ram_rdata1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW-1:0]    fail_addr,
  output logic             fail_port,
  output logic [15:0]      err_count
);

  localparam logic [WIDTH-1:0] PAT = WIDTH'(PATTERN);

  typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-2:0]     k_q, k_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [AW-1:0]     addr0_q, addr0_d, addr1_q, addr1_d;
  logic              wr_q, wr_d;
  logic [WIDTH-1:0]  wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [AW-1:0]     faddr_q, faddr_d;
  logic              fport_q, fport_d;
  logic [15:0]       err_q, err_d;

  // Stage 0 is issued together with the address; stage RD_LAT lines up with rdata.
  logic [RD_LAT:0]          pv_q, pv_d, pinv_q, pinv_d;
  logic [RD_LAT:0][AW-1:0]  pa0_q, pa0_d, pa1_q, pa1_d;

  logic [WIDTH-1:0] exp0, exp1;
  logic             mis0, mis1;
  logic [16:0]      sum;

  function automatic logic [WIDTH-1:0] pat_d(input logic [AW-1:0] a);
    return WIDTH'(a) ^ PAT;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    faddr_d = faddr_q;
    fport_d = fport_q;
    err_d   = err_q;

    exp0 = pinv_q[RD_LAT] ? ~pat_d(pa0_q[RD_LAT]) : pat_d(pa0_q[RD_LAT]);
    exp1 = pinv_q[RD_LAT] ? ~pat_d(pa1_q[RD_LAT]) : pat_d(pa1_q[RD_LAT]);
    mis0 = pv_q[RD_LAT] && (ram_rdata0 != exp0);
    mis1 = pv_q[RD_LAT] && (ram_rdata1 != exp1);
    sum  = {1'b0, err_q} + {16'b0, mis0} + {16'b0, mis1};
    if (mis0 || mis1) begin
      err_d = sum[16] ? '1 : sum[15:0];
      if (err_q == '0) begin
        faddr_d = mis0 ? pa0_q[RD_LAT] : pa1_q[RD_LAT];
        fport_d = !mis0;
      end
    end

    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WR0;
        k_d     = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        err_d   = '0;
        faddr_d = '0;
        fport_d = 1'b0;
      end
      WR0, RD0, WR1, RD1: begin
        k_d = k_q + 1'b1;
        if (k_q == '1) begin
          k_d     = '0;
          dcnt_d  = '0;
          state_d = (state_q == WR0) ? RD0 :
                    (state_q == RD0) ? DRN0 :
                    (state_q == WR1) ? RD1 : DRN1;
        end
      end
      DRN0, DRN1: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == 2'(RD_LAT - 1)) begin
          if (state_q == DRN0) begin
            state_d = WR1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the in-flight compare but keeps the accumulated result.
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      err_d   = err_q;
      faddr_d = faddr_q;
      fport_d = fport_q;
    end

    addr0_d  = '0;
    addr1_d  = '0;
    if (state_d == WR0 || state_d == RD0) begin
      addr0_d = {k_d, 1'b0};
      addr1_d = {k_d, 1'b1};
    end else if (state_d == WR1 || state_d == RD1) begin
      addr0_d = {k_d, 1'b1};
      addr1_d = {k_d, 1'b0};
    end
    wr_d     = (state_d == WR0) || (state_d == WR1);
    wdata0_d = '0;
    wdata1_d = '0;
    if (state_d == WR0) begin
      wdata0_d = pat_d(addr0_d);
      wdata1_d = pat_d(addr1_d);
    end else if (state_d == WR1) begin
      wdata0_d = ~pat_d(addr0_d);
      wdata1_d = ~pat_d(addr1_d);
    end

    pv_d[0]   = (state_d == RD0) || (state_d == RD1);
    pinv_d[0] = (state_d == RD1);
    pa0_d[0]  = addr0_d;
    pa1_d[0]  = addr1_d;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      pv_d[i]   = pv_q[i-1] && !abort;
      pinv_d[i] = pinv_q[i-1];
      pa0_d[i]  = pa0_q[i-1];
      pa1_d[i]  = pa1_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      dcnt_q   <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      wr_q     <= 1'b0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      faddr_q  <= '0;
      fport_q  <= 1'b0;
      err_q    <= '0;
      pv_q     <= '0;
      pinv_q   <= '0;
      pa0_q    <= '0;
      pa1_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      dcnt_q   <= dcnt_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      wr_q     <= wr_d;
      wdata0_q <= wdata0_d;
      wdata1_q <= wdata1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      faddr_q  <= faddr_d;
      fport_q  <= fport_d;
      err_q    <= err_d;
      pv_q     <= pv_d;
      pinv_q   <= pinv_d;
      pa0_q    <= pa0_d;
      pa1_q    <= pa1_d;
    end
  end

  assign ram_addr0  = addr0_q;
  assign ram_addr1  = addr1_q;
  assign ram_wr     = wr_q;
  assign ram_wdata0 = wdata0_q;
  assign ram_wdata1 = wdata1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = faddr_q;
  assign fail_port  = fport_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_ram_bist_seq.sv
// Bench for ram_bist_seq: RD_LAT=1 instance with fault-injecting RAM model plus a
// clean RD_LAT=3 instance; table-driven runs with a result scoreboard.
`timescale 1ns/1ps
module tb_ram_bist_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   fault = 0;

  logic [7:0]  a0_1, a1_1, fa1, a0_3, a1_3, fa3;
  logic        wr1, busy1, done1, pass1, fp1, wr3, busy3, done3, pass3, fp3;
  logic [31:0] wd0_1, wd1_1, rd0_1, rd1_1, wd0_3, wd1_3, rd0_3, rd1_3;
  logic [15:0] ec1, ec3;

  always #5 clk = ~clk;

  ram_bist_seq #(.WIDTH(32), .AW(8), .RD_LAT(1), .PATTERN(32'hA5A5A5A5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_addr0(a0_1), .ram_addr1(a1_1), .ram_wr(wr1),
    .ram_wdata0(wd0_1), .ram_wdata1(wd1_1), .ram_rdata0(rd0_1), .ram_rdata1(rd1_1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fa1), .fail_port(fp1), .err_count(ec1));

  ram_bist_seq #(.WIDTH(32), .AW(8), .RD_LAT(3), .PATTERN(32'hA5A5A5A5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_addr0(a0_3), .ram_addr1(a1_3), .ram_wr(wr3),
    .ram_wdata0(wd0_3), .ram_wdata1(wd1_3), .ram_rdata0(rd0_3), .ram_rdata1(rd1_3),
    .busy(busy3), .done(done3), .pass(pass3),
    .fail_addr(fa3), .fail_port(fp3), .err_count(ec3));

  // Read-path fault models: 1 bit0 stuck-at-1 @0x10, 2 bit0 stuck-at-0 @0x10,
  // 3 both ports inverted when addr0=6/addr1=7, 4 every read inverted.
  function automatic logic [31:0] flt(input logic [31:0] d, input logic [7:0] a,
                                      input logic [7:0] p0, input logic [7:0] p1,
                                      input int f);
    logic [31:0] r;
    r = d;
    case (f)
      1: if (a == 8'h10) r[0] = 1'b1;
      2: if (a == 8'h10) r[0] = 1'b0;
      3: if (p0 == 8'h06 && p1 == 8'h07) r = ~r;
      4: r = ~r;
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p0a, p0b, p1a, p1b;

  always @(posedge clk) begin
    if (wr1) begin
      mem1[a0_1] <= wd0_1;
      mem1[a1_1] <= wd1_1;
    end
    rd0_1 <= flt(mem1[a0_1], a0_1, a0_1, a1_1, fault);
    rd1_1 <= flt(mem1[a1_1], a1_1, a0_1, a1_1, fault);
  end

  always @(posedge clk) begin
    if (wr3) begin
      mem3[a0_3] <= wd0_3;
      mem3[a1_3] <= wd1_3;
    end
    p0a <= mem3[a0_3];  p0b <= p0a;  rd0_3 <= p0b;
    p1a <= mem3[a1_3];  p1b <= p1a;  rd1_3 <= p1b;
  end

  // Independent model of the write walk of the RD_LAT=1 instance.
  int wcnt = 0;
  int wr_bad = 0;
  always @(negedge clk) begin
    int j, ph;
    logic [7:0]  ea0, ea1;
    logic [31:0] ed0, ed1;
    if (!busy1) wcnt = 0;
    else if (wr1) begin
      j   = wcnt % 128;
      ph  = wcnt / 128;
      ea0 = (ph == 1) ? 8'(2*j+1) : 8'(2*j);
      ea1 = (ph == 1) ? 8'(2*j)   : 8'(2*j+1);
      ed0 = {24'h0, ea0} ^ 32'hA5A5A5A5;
      ed1 = {24'h0, ea1} ^ 32'hA5A5A5A5;
      if (ph == 1) begin ed0 = ~ed0; ed1 = ~ed1; end
      if (ph > 1 || a0_1 !== ea0 || a1_1 !== ea1 || wd0_1 !== ed0 || wd1_1 !== ed1)
        wr_bad = wr_bad + 1;
      wcnt = wcnt + 1;
    end
  end

  typedef struct { int fault; int abort_at; logic pass; logic [15:0] err;
                   logic [7:0] faddr; logic fport; } vec_t;
  typedef struct { logic pass; logic [15:0] err; logic [7:0] faddr; logic fport; } exp_t;

  exp_t exp_q[$];
  vec_t tv[7];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"},   {busy1, done1, pass1, wr1, fp1}, 0);
    chk({tag, "_addr"},  {a0_1, a1_1, fa1}, 0);
    chk({tag, "_wdata"}, {wd0_1, wd1_1}, 0);
    chk({tag, "_err"},   ec1, 0);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty scoreboard, expected an entry", tag);
    end else begin
      checks--;
      e = exp_q.pop_front();
      chk({tag, "_pass"},  pass1, e.pass);
      chk({tag, "_err"},   ec1,   e.err);
      chk({tag, "_faddr"}, fa1,   e.faddr);
      chk({tag, "_fport"}, fp1,   e.fport);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit drop, output int c1, output int c3, output int wc);
    c1 = -1; c3 = -1; wc = -1;
    for (int c = 1; c <= 1500 && (c1 < 0 || c3 < 0); c++) begin
      tick();
      if (done1 && c1 < 0) begin
        c1 = c;
        wc = wcnt;
        if (drop) start = 1'b0;
      end
      if (done3 && c3 < 0) c3 = c;
    end
  endtask

  task automatic run_checks(input string tag, input int c1, input int c3, input int wc);
    chk({tag, "_done_cyc"}, c1, 514);
    chk({tag, "_wr_count"}, wc, 256);
    check_sb(tag);
    chk({tag, "_lat3_cyc"},  c3, 518);
    chk({tag, "_lat3_pass"}, {pass3, ec3}, {1'b1, 16'h0});
  endtask

  initial begin
    int c1, c3, wc;
    tv[0] = '{0, 0,   1'b1, 16'd0,   8'h00, 1'b0};
    tv[1] = '{1, 0,   1'b0, 16'd1,   8'h10, 1'b1};
    tv[2] = '{2, 0,   1'b0, 16'd1,   8'h10, 1'b0};
    tv[3] = '{3, 0,   1'b0, 16'd2,   8'h06, 1'b0};
    tv[4] = '{4, 0,   1'b0, 16'd512, 8'h00, 1'b0};
    tv[5] = '{4, 200, 1'b0, 16'd140, 8'h00, 1'b0};
    tv[6] = '{0, 0,   1'b1, 16'd0,   8'h00, 1'b0};

    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      fault = tv[i].fault;
      exp_q.push_back('{tv[i].pass, tv[i].err, tv[i].faddr, tv[i].fport});
      start_pulse();
      chk($sformatf("v%0d_busy", i), {busy1, done1}, 2'b10);
      if (tv[i].abort_at != 0) begin
        for (int c = 1; c < tv[i].abort_at; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("v%0d_abort_idle", i), {busy1, done1, wr1}, 3'b000);
        check_sb($sformatf("v%0d", i));
      end else begin
        wait_done(1'b0, c1, c3, wc);
        run_checks($sformatf("v%0d", i), c1, c3, wc);
      end
      repeat (4) tick();
    end
    chk("write_walk", wr_bad, 0);

    // start held high across the whole run: exactly one run, then restart from DONE
    fault = 0;
    exp_q.push_back('{1'b1, 16'd0, 8'h00, 1'b0});
    start = 1'b1;
    tick();
    wait_done(1'b1, c1, c3, wc);
    run_checks("held", c1, c3, wc);
    repeat (6) tick();
    chk("held_single_run", {done1, busy1}, 2'b10);
    exp_q.push_back('{1'b1, 16'd0, 8'h00, 1'b0});
    start_pulse();
    chk("restart_done_drop", {done1, busy1}, 2'b01);
    wait_done(1'b0, c1, c3, wc);
    run_checks("restart", c1, c3, wc);
    repeat (4) tick();

    // asynchronous reset in the middle of a run
    start_pulse();
    repeat (299) tick();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back('{1'b1, 16'd0, 8'h00, 1'b0});
    start_pulse();
    wait_done(1'b0, c1, c3, wc);
    run_checks("post_rst", c1, c3, wc);
    chk("write_walk_final", wr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule
